// File: rtl/npu_pool_pkg.sv
// Shared types and helpers for the streaming 2-D pooling block.
package npu_pool_pkg;

  typedef enum logic {
    ModeMax = 1'b0,
    ModeAvg = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } pool_state_e;

  // Wide enough to hold the sum of (2**max_klog2)**2 signed elements.
  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned max_klog2);
    return data_width + 2 * max_klog2;
  endfunction

endpackage

// File: rtl/pool2d_stream_if.sv
// Control, input-stream and output-stream signals of pool2d_stream.
interface pool2d_stream_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANES      = 4,
  parameter int unsigned MAX_WIDTH  = 64
) ();

  localparam int unsigned WW = $clog2(MAX_WIDTH + 1);

  logic                        clear_i;
  logic                        start_i;
  logic                        mode_i;
  logic [1:0]                  klog2_i;
  logic [WW-1:0]               img_w_i;
  logic [15:0]                 img_h_i;
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic [LANES*DATA_WIDTH-1:0] in_data_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [LANES*DATA_WIDTH-1:0] out_data_o;
  logic                        busy_o;
  logic                        done_o;

  modport slave (
    input  clear_i, start_i, mode_i, klog2_i, img_w_i, img_h_i,
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, busy_o, done_o
  );

  modport master (
    output clear_i, start_i, mode_i, klog2_i, img_w_i, img_h_i,
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, busy_o, done_o
  );

endinterface

// File: rtl/pool2d_lane_op.sv
// Per-lane max/add combine for horizontal and vertical window passes plus final scaling.
// Define POOL2D_ROUND_EN for half-up rounding of averages; default truncates toward -inf.
module pool2d_lane_op
  import npu_pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_KLOG2  = 3,
  localparam int unsigned AccW      = acc_width(DATA_WIDTH, MAX_KLOG2)
) (
  input  pool_mode_e            mode_i,
  input  logic [1:0]            klog2_i,
  input  logic [DATA_WIDTH-1:0] pix_i,
  input  logic [AccW-1:0]       hacc_i,
  input  logic                  hfirst_i,
  input  logic [AccW-1:0]       col_i,
  input  logic                  vfirst_i,
  output logic [AccW-1:0]       hacc_o,
  output logic [AccW-1:0]       vacc_o,
  output logic [DATA_WIDTH-1:0] res_o
);

  function automatic logic [AccW-1:0] combine(input pool_mode_e mode,
                                              input logic [AccW-1:0] a,
                                              input logic [AccW-1:0] b);
    if (mode == ModeMax) return ($signed(a) > $signed(b)) ? a : b;
    return a + b;
  endfunction

  logic [AccW-1:0]        pix_ext;
  logic [AccW-1:0]        rnd;
  logic [2:0]             shamt;
  logic signed [AccW-1:0] sum_s;
  logic signed [AccW-1:0] avg_s;

  always_comb begin
    pix_ext = {{(AccW - DATA_WIDTH){pix_i[DATA_WIDTH-1]}}, pix_i};
    hacc_o  = hfirst_i ? pix_ext : combine(mode_i, hacc_i, pix_ext);
    vacc_o  = vfirst_i ? hacc_o : combine(mode_i, col_i, hacc_o);
    shamt   = {klog2_i, 1'b0};
    rnd     = '0;
`ifdef POOL2D_ROUND_EN
    if (klog2_i != 2'd0) rnd = AccW'(1) << (shamt - 3'd1);
`endif
    sum_s   = $signed(vacc_o + rnd);
    avg_s   = sum_s >>> shamt;
    res_o   = (mode_i == ModeMax) ? vacc_o[DATA_WIDTH-1:0] : avg_s[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/pool2d_stream.sv
// Streaming non-overlapping KxK max/average pooling over a row-major pixel stream.
// Rounding of averages is selected at build time by POOL2D_ROUND_EN (see pool2d_lane_op).
module pool2d_stream
  import npu_pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANES      = 4,
  parameter int unsigned MAX_WIDTH  = 64,
  parameter int unsigned MAX_KLOG2  = 3
) (
  input logic            clk_i,
  input logic            rst_ni,
  pool2d_stream_if.slave bus
);

  localparam int unsigned AccW = acc_width(DATA_WIDTH, MAX_KLOG2);
  localparam int unsigned WW   = $clog2(MAX_WIDTH + 1);
  localparam int unsigned IdxW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int unsigned KW   = MAX_KLOG2;

  pool_state_e                 state_q;
  pool_mode_e                  mode_q;
  logic [1:0]                  klog2_q;
  logic [WW-1:0]               w_q, col_q, ocol_q;
  logic [15:0]                 h_q, row_q, orow_q;
  logic [KW-1:0]               kx_q, ky_q;
  logic                        out_valid_q, done_q;
  logic [LANES*DATA_WIDTH-1:0] out_data_q;
  logic [AccW-1:0]             hacc_q   [LANES];
  logic [AccW-1:0]             colbuf_q [MAX_WIDTH][LANES];

  logic                        in_ready, accept, kx_last, ky_last, last_col, last_pix;
  logic                        in_win, col_we, emit;
  logic [KW-1:0]               kmask;
  logic [IdxW-1:0]             col_idx;
  logic [AccW-1:0]             hacc_d   [LANES];
  logic [AccW-1:0]             vacc_d   [LANES];
  logic [DATA_WIDTH-1:0]       res_lane [LANES];
  logic [LANES*DATA_WIDTH-1:0] res_word;

  always_comb begin
    kmask    = KW'((32'd1 << klog2_q) - 32'd1);
    kx_last  = (kx_q == kmask);
    ky_last  = (ky_q == kmask);
    in_ready = (state_q == StRun) && (!out_valid_q || bus.out_ready_i);
    accept   = in_ready && bus.in_valid_i;
    last_col = (col_q == w_q - WW'(1));
    last_pix = last_col && (row_q == h_q - 16'd1);
    // Trailing partial windows (W mod K, H mod K) fall outside this region.
    in_win   = (ocol_q < (w_q >> klog2_q)) && (orow_q < (h_q >> klog2_q));
    col_we   = accept && in_win && kx_last;
    emit     = col_we && ky_last;
    col_idx  = ocol_q[IdxW-1:0];
    res_word = '0;
    for (int l = 0; l < LANES; l++) res_word[l*DATA_WIDTH +: DATA_WIDTH] = res_lane[l];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pool2d_lane_op #(
      .DATA_WIDTH(DATA_WIDTH),
      .MAX_KLOG2 (MAX_KLOG2)
    ) u_lane_op (
      .mode_i  (mode_q),
      .klog2_i (klog2_q),
      .pix_i   (bus.in_data_i[l*DATA_WIDTH +: DATA_WIDTH]),
      .hacc_i  (hacc_q[l]),
      .hfirst_i(kx_q == '0),
      .col_i   (colbuf_q[col_idx][l]),
      .vfirst_i(ky_q == '0),
      .hacc_o  (hacc_d[l]),
      .vacc_o  (vacc_d[l]),
      .res_o   (res_lane[l])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      mode_q      <= ModeMax;
      klog2_q     <= '0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      ocol_q      <= '0;
      row_q       <= '0;
      orow_q      <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      for (int l = 0; l < LANES; l++) hacc_q[l] <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.clear_i) begin
        state_q     <= StIdle;
        out_valid_q <= 1'b0;
      end else begin
        if (emit) begin
          out_valid_q <= 1'b1;
          out_data_q  <= res_word;
        end else if (bus.out_ready_i) begin
          out_valid_q <= 1'b0;
        end
        if (accept && in_win) begin
          for (int l = 0; l < LANES; l++) hacc_q[l] <= hacc_d[l];
        end
        unique case (state_q)
          StIdle: begin
            if (bus.start_i) begin
              mode_q  <= pool_mode_e'(bus.mode_i);
              klog2_q <= bus.klog2_i;
              w_q     <= bus.img_w_i;
              h_q     <= bus.img_h_i;
              col_q   <= '0;
              ocol_q  <= '0;
              row_q   <= '0;
              orow_q  <= '0;
              kx_q    <= '0;
              ky_q    <= '0;
              // An empty frame has no last pixel to wait for.
              state_q <= (bus.img_w_i == '0 || bus.img_h_i == '0) ? StDrain : StRun;
            end
          end
          StRun: begin
            if (accept) begin
              if (last_col) begin
                col_q  <= '0;
                kx_q   <= '0;
                ocol_q <= '0;
                row_q  <= row_q + 16'd1;
                if (ky_last) begin
                  ky_q   <= '0;
                  orow_q <= orow_q + 16'd1;
                end else begin
                  ky_q <= ky_q + KW'(1);
                end
              end else begin
                col_q <= col_q + WW'(1);
                if (kx_last) begin
                  kx_q   <= '0;
                  ocol_q <= ocol_q + WW'(1);
                end else begin
                  kx_q <= kx_q + KW'(1);
                end
              end
              if (last_pix) state_q <= StDrain;
            end
          end
          StDrain: begin
            if (!out_valid_q) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // The entry is zeroed once its window row completes; ky==0 overwrites it regardless.
  always_ff @(posedge clk_i) begin
    if (col_we) begin
      for (int l = 0; l < LANES; l++) colbuf_q[col_idx][l] <= ky_last ? '0 : vacc_d[l];
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.done_o      = done_q;

endmodule
